// File: rtl/pipe_pkg.sv
// Shared types for the n-way skid stage register.
// State encoding, default payload width, producer field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int PAYLOAD_W_DEF = 160;

  // Per-slot field layout used by producers and consumers.
  localparam int RD_ADDR_LSB = 0;
  localparam int RD_ADDR_W   = 5;
  localparam int RD_WE_LSB   = 5;
  localparam int OP1_LSB     = 6;
  localparam int OP2_LSB     = 38;
  localparam int OPND_W      = 32;
  localparam int IMM_LSB     = 70;
  localparam int IMM_W       = 32;
  localparam int OPCODE_LSB  = 102;
  localparam int OPCODE_W    = 7;
  localparam int FUNCT3_LSB  = 109;
  localparam int FUNCT3_W    = 3;
  localparam int FUNCT7_LSB  = 112;
  localparam int FUNCT7_W    = 7;
  localparam int SHAMT_LSB   = 119;
  localparam int SHAMT_W     = 5;
  localparam int FIELDS_USED = 124;

  function automatic int slot_lsb(input int k, input int pw);
    return k * pw;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered bundle entry: {valid[WAYS], payload, seq}.
// Ports: clk, reset, clr (kills valids), ld, *_d in, *_q out.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int SEQ_W     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      ld,
  input  logic [WAYS-1:0]           valid_d,
  input  logic [WAYS*PAYLOAD_W-1:0] payload_d,
  input  logic [SEQ_W-1:0]          seq_d,
  output logic [WAYS-1:0]           valid_q,
  output logic [WAYS*PAYLOAD_W-1:0] payload_q,
  output logic [SEQ_W-1:0]          seq_q
);

  // Clear only drops the valids; payload and tag hold
  // until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      payload_q <= '0;
      seq_q     <= '0;
    end else if (clr) begin
      valid_q   <= '0;
    end else if (ld) begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      seq_q     <= seq_d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg_nway.sv
// N-way valid/ready stage register with main+skid entry, flush, seq tags.
// Ports: clk, reset, flush_i, valid_i/payload_i/ready_o (upstream),
// valid_o/payload_o/seq_o/ready_i (downstream).
// Build macro PIPE_PERF_CNT_EN adds stall_cnt_o and flush_cnt_o.
module pipe_skid_reg_nway
  import pipe_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int SEQ_W     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [WAYS-1:0]           valid_i,
  input  logic [WAYS*PAYLOAD_W-1:0] payload_i,
  output logic                      ready_o,
  output logic [WAYS-1:0]           valid_o,
  output logic [WAYS*PAYLOAD_W-1:0] payload_o,
  output logic [SEQ_W-1:0]          seq_o,
  input  logic                      ready_i
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
`endif
);

  state_t state_q, state_d;

  logic acc, dsp;
  logic m_ld, m_clr, m_sel_skid;
  logic s_ld, s_clr;
  logic [SEQ_W-1:0] seq_cnt;

  logic [WAYS-1:0]           s_valid;
  logic [WAYS*PAYLOAD_W-1:0] s_payload;
  logic [SEQ_W-1:0]          s_seq;

  logic [WAYS-1:0]           m_valid_d;
  logic [WAYS*PAYLOAD_W-1:0] m_payload_d;
  logic [SEQ_W-1:0]          m_seq_d;

  assign acc = (|valid_i) && ready_o && !flush_i;
  assign dsp = (|valid_o) && ready_i;

  always_comb begin
    state_d    = state_q;
    m_ld       = 1'b0;
    m_clr      = 1'b0;
    m_sel_skid = 1'b0;
    s_ld       = 1'b0;
    s_clr      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_BUSY;
            m_ld    = 1'b1;
          end
        end
        ST_BUSY: begin
          if (acc && dsp) begin
            m_ld = 1'b1;
          end else if (acc) begin
            state_d = ST_FULL;
            s_ld    = 1'b1;
          end else if (dsp) begin
            state_d = ST_EMPTY;
            m_clr   = 1'b1;
          end
        end
        ST_FULL: begin
          // Skid drains into main on the same edge.
          if (dsp) begin
            state_d    = ST_BUSY;
            m_ld       = 1'b1;
            m_sel_skid = 1'b1;
            s_clr      = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ready_o <= 1'b1;
      seq_cnt <= '0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d != ST_FULL);
      if (acc)
        seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  assign m_valid_d   = m_sel_skid ? s_valid   : valid_i;
  assign m_payload_d = m_sel_skid ? s_payload : payload_i;
  assign m_seq_d     = m_sel_skid ? s_seq     : seq_cnt;

  pipe_entry_reg #(
    .WAYS(WAYS), .PAYLOAD_W(PAYLOAD_W), .SEQ_W(SEQ_W)
  ) u_main (
    .clk(clk), .reset(reset),
    .clr(m_clr), .ld(m_ld),
    .valid_d(m_valid_d), .payload_d(m_payload_d),
    .seq_d(m_seq_d),
    .valid_q(valid_o), .payload_q(payload_o),
    .seq_q(seq_o)
  );

  pipe_entry_reg #(
    .WAYS(WAYS), .PAYLOAD_W(PAYLOAD_W), .SEQ_W(SEQ_W)
  ) u_skid (
    .clk(clk), .reset(reset),
    .clr(s_clr), .ld(s_ld),
    .valid_d(valid_i), .payload_d(payload_i),
    .seq_d(seq_cnt),
    .valid_q(s_valid), .payload_q(s_payload),
    .seq_q(s_seq)
  );

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((|valid_o) && !ready_i && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
